// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg: shared types and helpers for the branch-predictor update controller.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bp_pkg;

   localparam int BP_INDEX_W_DEF = 8;
   localparam int BP_IDX_MAX_W   = 30;

   // Entries carry the widest legal index; narrower tables leave the top bits zero.
   typedef struct packed {
      logic [BP_IDX_MAX_W-1:0] index;
      logic                    pred;
   } bp_entry_t;

   typedef enum logic [0:0] {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } bp_state_t;

   function automatic logic [BP_IDX_MAX_W-1:0] pc_to_index(input logic [31:0] pc,
                                                           input int unsigned index_w);
      logic [BP_IDX_MAX_W-1:0] mask;
      mask = (BP_IDX_MAX_W'(1) << index_w) - BP_IDX_MAX_W'(1);
      return pc[BP_IDX_MAX_W+1:2] & mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
// ---------------------------------------------------------------------------
// bp_inflight_fifo: in-order queue of unresolved branches (push/pop/clear).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  bp_entry_t                  i_data,
   input  logic                       i_pop,
   input  logic                       i_clear,
   output bp_entry_t                  o_head,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   bp_entry_t            r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;

   logic w_empty;
   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_cnt_w'(DEPTH));
   // A full queue may still accept a push when the head leaves in the same cycle.
   assign w_do_pop  = i_pop && !w_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !reset && !i_clear) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl: pipeline-side get/set/reset driver for the 2-bit predictor table.
// Rev 1.0  -- define BP_STATS_EN to add saturating stat_pred/stat_mispred counters.
// ---------------------------------------------------------------------------
`default_nettype none

module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int INDEX_W = BP_INDEX_W_DEF,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_valid,
   input  logic [31:0]        fetch_pc,
   output logic               fetch_ready,
   output logic               pred_valid,
   output logic               pred_taken,
   input  logic               resolve_valid,
   input  logic               resolve_taken,
   input  logic               flush,
   output logic               mispredict,
   output logic               resolve_err,
   output logic               get,
   output logic [INDEX_W-1:0] get_index,
   input  logic               prediction,
   output logic               set,
   output logic [INDEX_W-1:0] set_index,
   output logic               feedback,
   output logic               tbl_reset,
   output logic [INDEX_W-1:0] tbl_reset_index
`ifdef BP_STATS_EN
   ,
   output logic [15:0]        stat_pred,
   output logic [15:0]        stat_mispred
`endif
);

   localparam int                 c_cnt_w    = $clog2(DEPTH) + 1;
   localparam logic [INDEX_W-1:0] c_last_idx = '1;

   bp_state_t              r_state;
   logic                   r_tbl_reset;
   logic [INDEX_W-1:0]     r_tbl_idx;
   logic                   r_pend_get;
   logic [BP_IDX_MAX_W-1:0] r_pend_idx;
   logic                   r_mispred;
   logic                   r_err;

   logic                   w_run;
   logic                   w_fetch_acc;
   logic [BP_IDX_MAX_W-1:0] w_index;
   logic [c_cnt_w-1:0]     w_count;
   logic [c_cnt_w:0]       w_inflight;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_res;
   logic                   w_err_ev;
   logic                   w_misp_nxt;
   bp_entry_t              w_head;
   bp_entry_t              w_push_data;
   logic                   w_unused;

   assign w_run   = (r_state == ST_RUN);
   assign w_index = pc_to_index(fetch_pc, INDEX_W);
   assign w_empty = (w_count == '0);

   // A get issued last cycle already owns a slot even though it is not queued yet.
   assign w_inflight  = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_pend_get};
   assign fetch_ready = w_run && !flush && (w_inflight < (c_cnt_w + 1)'(DEPTH));
   assign w_fetch_acc = fetch_valid && fetch_ready;

   assign get       = w_fetch_acc;
   assign get_index = w_fetch_acc ? w_index[INDEX_W-1:0] : '0;

   assign pred_valid = r_pend_get;
   assign pred_taken = r_pend_get & prediction;

   assign w_push            = r_pend_get && !flush;
   assign w_push_data.index = r_pend_idx;
   assign w_push_data.pred  = prediction;

   assign w_res      = w_run && resolve_valid && !w_empty;
   assign w_err_ev   = w_run && resolve_valid && w_empty;
   assign w_misp_nxt = w_res && (w_head.pred ^ resolve_taken);

   assign set       = w_res;
   assign set_index = w_res ? w_head.index[INDEX_W-1:0] : '0;
   assign feedback  = w_res & resolve_taken;

   assign mispredict      = r_mispred;
   assign resolve_err     = r_err;
   assign tbl_reset       = r_tbl_reset;
   assign tbl_reset_index = r_tbl_idx;

   assign w_unused = ^{fetch_pc[1:0], w_index[BP_IDX_MAX_W-1:INDEX_W],
                       w_head.index[BP_IDX_MAX_W-1:INDEX_W]};

   bp_inflight_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_res),
      .i_clear (flush),
      .o_head  (w_head),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_SWEEP;
         r_tbl_reset <= 1'b0;
         r_tbl_idx   <= '0;
      end else begin
         case (r_state)
            ST_SWEEP: begin
               if (!r_tbl_reset) begin
                  r_tbl_reset <= 1'b1;
               end else if (r_tbl_idx == c_last_idx) begin
                  r_tbl_reset <= 1'b0;
                  r_tbl_idx   <= '0;
                  r_state     <= ST_RUN;
               end else begin
                  r_tbl_idx <= r_tbl_idx + INDEX_W'(1);
               end
            end
            ST_RUN: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state     <= ST_SWEEP;
               r_tbl_reset <= 1'b0;
               r_tbl_idx   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend_get <= 1'b0;
         r_pend_idx <= '0;
         r_mispred  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_pend_get <= w_fetch_acc;
         r_pend_idx <= w_index;
         r_mispred  <= w_misp_nxt;
         if (w_err_ev) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef BP_STATS_EN
   logic [15:0] r_stat_pred;
   logic [15:0] r_stat_mispred;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_pred    <= '0;
         r_stat_mispred <= '0;
      end else begin
         if (w_push && (r_stat_pred != 16'hFFFF)) begin
            r_stat_pred <= r_stat_pred + 16'd1;
         end
         if (w_misp_nxt && (r_stat_mispred != 16'hFFFF)) begin
            r_stat_mispred <= r_stat_mispred + 16'd1;
         end
      end
   end

   assign stat_pred    = r_stat_pred;
   assign stat_mispred = r_stat_mispred;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_update_ctrl: scoreboard bench for bp_update_ctrl with a stub predictor table.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bp_update_ctrl;

   localparam int INDEX_W = 8;
   localparam int DEPTH   = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               fetch_valid = 1'b0;
   logic [31:0]        fetch_pc = '0;
   logic               fetch_ready;
   logic               pred_valid;
   logic               pred_taken;
   logic               resolve_valid = 1'b0;
   logic               resolve_taken = 1'b0;
   logic               flush = 1'b0;
   logic               mispredict;
   logic               resolve_err;
   logic               get;
   logic [INDEX_W-1:0] get_index;
   logic               prediction = 1'b0;
   logic               set;
   logic [INDEX_W-1:0] set_index;
   logic               feedback;
   logic               tbl_reset;
   logic [INDEX_W-1:0] tbl_reset_index;
`ifdef BP_STATS_EN
   logic [15:0]        stat_pred;
   logic [15:0]        stat_mispred;
`endif

   always #5 clk = ~clk;

   bp_update_ctrl #(
      .INDEX_W (INDEX_W),
      .DEPTH   (DEPTH)
   ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_valid     (fetch_valid),
      .fetch_pc        (fetch_pc),
      .fetch_ready     (fetch_ready),
      .pred_valid      (pred_valid),
      .pred_taken      (pred_taken),
      .resolve_valid   (resolve_valid),
      .resolve_taken   (resolve_taken),
      .flush           (flush),
      .mispredict      (mispredict),
      .resolve_err     (resolve_err),
      .get             (get),
      .get_index       (get_index),
      .prediction      (prediction),
      .set             (set),
      .set_index       (set_index),
      .feedback        (feedback),
      .tbl_reset       (tbl_reset),
      .tbl_reset_index (tbl_reset_index)
`ifdef BP_STATS_EN
      ,
      .stat_pred       (stat_pred),
      .stat_mispred    (stat_mispred)
`endif
   );

   // Stub table: fixed per-index contents, answers the cycle after a get.
   function automatic logic tbl_val(input logic [7:0] idx);
      return (32'(idx) % 32'd3) != 32'd0;
   endfunction

   always @(posedge clk) begin
      if (get) prediction <= tbl_val(get_index);
   end

   typedef struct {
      logic [7:0] idx;
      logic       pred;
   } ent_t;

   ent_t       m_q[$];
   logic       exp_pred_q[$];
   bit         m_pend;
   logic [7:0] m_pend_idx;
   bit         m_err;
   int         m_spred;
   int         m_smisp;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      fetch_valid   = 1'b0;
      resolve_valid = 1'b0;
      flush         = 1'b0;
      reset         = 1'b1;
      step();
      reset = 1'b0;
      check("rst_tbl_reset", tbl_reset, 1'b0);
      check("rst_tbl_idx", tbl_reset_index, 8'd0);
      check("rst_fetch_ready", fetch_ready, 1'b0);
      check("rst_pred_valid", pred_valid, 1'b0);
      check("rst_mispredict", mispredict, 1'b0);
      check("rst_resolve_err", resolve_err, 1'b0);
`ifdef BP_STATS_EN
      check("rst_stat_pred", stat_pred, 16'd0);
      check("rst_stat_mispred", stat_mispred, 16'd0);
`endif
      m_q.delete();
      exp_pred_q.delete();
      m_pend  = 0;
      m_err   = 0;
      m_spred = 0;
      m_smisp = 0;
      step();
   endtask

   task automatic sweep(input int n);
      for (int i = 0; i < n; i++) begin
         check("sweep_tbl_reset", tbl_reset, 1'b1);
         check("sweep_idx", tbl_reset_index, 32'(i));
         check("sweep_fetch_ready", fetch_ready, 1'b0);
         step();
      end
   endtask

   task automatic cyc(input bit fv, input logic [31:0] pc, input bit rv, input bit rt, input bit fl);
      bit         rdy, acc, res, misp;
      logic       pv;
      logic [7:0] idx;
      ent_t       head;
      fetch_valid   = fv;
      fetch_pc      = pc;
      resolve_valid = rv;
      resolve_taken = rt;
      flush         = fl;
      #1;
      rdy = !fl && ((m_q.size() + int'(m_pend)) < DEPTH);
      acc = fv && rdy;
      idx = pc[9:2];
      pv  = 1'b0;
      check("fetch_ready", fetch_ready, rdy);
      check("get", get, acc);
      if (acc) begin
         check("get_index", get_index, idx);
         exp_pred_q.push_back(tbl_val(idx));
      end
      check("pred_valid", pred_valid, m_pend);
      if (pred_valid) begin
         if (exp_pred_q.size() == 0) check("pred_unexpected", 1'b1, 1'b0);
         else begin
            pv = exp_pred_q.pop_front();
            check("pred_taken", pred_taken, pv);
         end
      end
      res  = rv && (m_q.size() > 0);
      misp = 1'b0;
      check("set", set, res);
      if (res) begin
         head = m_q.pop_front();
         check("set_index", set_index, head.idx);
         check("feedback", feedback, rt);
         misp = head.pred ^ rt;
      end else if (rv) begin
         m_err = 1'b1;
      end
      if (m_pend && !fl) begin
         m_q.push_back('{m_pend_idx, pv});
         if (m_spred < 16'hFFFF) m_spred++;
      end
      if (fl) m_q.delete();
      if (misp && m_smisp < 16'hFFFF) m_smisp++;
      m_pend     = acc;
      m_pend_idx = idx;
      step();
      check("mispredict", mispredict, misp);
      check("resolve_err", resolve_err, m_err);
`ifdef BP_STATS_EN
      check("stat_pred", stat_pred, m_spred);
      check("stat_mispred", stat_mispred, m_smisp);
`endif
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      apply_reset();
      sweep(256);
      check("post_sweep_tbl_reset", tbl_reset, 1'b0);
      check("post_sweep_ready", fetch_ready, 1'b1);

      // single branch, predicted taken, resolved not-taken
      cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      idle();
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();

      // fill the queue, then drain in order with overlapping fetches
      cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h44, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 32'h48, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, i[0], 1'b0);
      idle();

      // flush with same-cycle resolve, then resolve on empty queue
      cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
      idle();
      cyc(1'b1, 32'h28, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

      // mixed random traffic
      for (int i = 0; i < 300; i++) begin
         cyc(1'(($urandom % 3) != 0), $urandom, 1'(($urandom % 3) == 0),
             1'($urandom % 2), 1'(($urandom % 20) == 0));
      end

      // reset in the middle of the sweep restarts it from index 0
      apply_reset();
      sweep(100);
      check("mid_sweep_idx", tbl_reset_index, 8'd100);
      apply_reset();
      sweep(256);
      check("resweep_ready", fetch_ready, 1'b1);

      // three predictions, one mispredict
      cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
      idle();
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();
      check("final_resolve_err", resolve_err, 1'b0);
`ifdef BP_STATS_EN
      check("final_stat_pred", stat_pred, 16'd3);
      check("final_stat_mispred", stat_mispred, 16'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
Pipeline-side controller for the indexed two-bit-counter predictor table; drives its get/set/reset interface from the other end. On a fetched branch it issues a get, captures the returned prediction and tracks up to DEPTH in-flight branches in an in-order queue. On branch resolution it writes the outcome back with set/feedback and flags a mispredict. After reset it sweeps every table entry through the table's per-entry reset.

Parameters:
INDEX_W, 8, table index width (table has 2**INDEX_W entries)
DEPTH, 4, max in-flight unresolved branches (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
fetch_valid  in  1  branch fetched this cycle
fetch_pc  in  32  branch PC; index = fetch_pc[INDEX_W+1:2]
fetch_ready  out  1  fetch accepted when fetch_valid && fetch_ready
pred_valid  out  1  pred_taken valid (one cycle)
pred_taken  out  1  prediction returned to pipeline
resolve_valid  in  1  oldest in-flight branch resolved
resolve_taken  in  1  actual outcome
flush  in  1  discard all in-flight entries, no table update
mispredict  out  1  registered, one cycle after resolve
resolve_err  out  1  sticky: resolve with empty queue
get  out  1  table read strobe
get_index  out  INDEX_W  table read index
prediction  in  1  table output, valid cycle after get
set  out  1  table update strobe
set_index  out  INDEX_W  table update index
feedback  out  1  outcome for update (1 = taken)
tbl_reset  out  1  per-entry table reset strobe
tbl_reset_index  out  INDEX_W  entry being reset

Behaviour:
- Reset values: all outputs 0; queue empty; FSM enters SWEEP.
- FSM: SWEEP -> RUN. SWEEP: tbl_reset=1, tbl_reset_index counts 0..2**INDEX_W-1, one per cycle; fetch_ready=0; resolve_valid ignored. Leave SWEEP the cycle after last index. RUN: normal operation, no return to SWEEP except via reset.
- Reset asserted mid-sweep or mid-RUN: queue cleared, sweep restarts at index 0.
- Fetch accepted cycle N: get=1, get_index driven combinationally in cycle N. Cycle N+1: pred_valid=1, pred_taken=prediction, entry {index, prediction} pushed. Latency fetch -> pred_valid = 1 cycle.
- fetch_ready = RUN && (count + pending_get) < DEPTH, where pending_get is the get issued last cycle.
- Resolve (RUN, queue non-empty): same cycle set=1, set_index=head.index, feedback=resolve_taken; head popped. Next cycle mispredict = head.pred XOR resolve_taken.
- Resolve with empty queue: no set, no pop, resolve_err set until reset.
- Push and pop same cycle allowed; count unchanged. Wrap-around: read/write pointers modulo DEPTH.
- flush: queue cleared and pending get's prediction discarded (pred_valid still pulses, nothing pushed). Same-cycle resolve is processed first (set issued), then clear. Same-cycle fetch is refused (fetch_ready=0 while flush=1).
- get and set to the same index in one cycle permitted; both driven, table ordering applies.
- count width clog2(DEPTH)+1, never exceeds DEPTH.

Optional Feature:
BP_STATS_EN: adds outputs stat_pred[15:0] (increments on each pred_valid that pushes) and stat_mispred[15:0] (increments on each mispredict); both saturate at 16'hFFFF, clear on reset. Without the macro these ports and counters do not exist.

Decomposition:
- Package bp_pkg: INDEX_W default, queue entry struct {index, pred}, FSM state enum {SWEEP, RUN}, pc-to-index function.
- One sub-module: bp_inflight_fifo (DEPTH-entry sync FIFO, push/pop/clear, count output).

Test Plan:
- Reset 1 cycle, INDEX_W=8 -> tbl_reset high 256 cycles, tbl_reset_index 0..255, fetch_ready 0 throughout, then 1.
- Fetch pc=0x10 (index 4), table returns 1 -> get=1 get_index=4 same cycle; pred_valid=1 pred_taken=1 next cycle.
- Then resolve_taken=0 -> set=1 set_index=4 feedback=0; mispredict=1 one cycle later.
- 4 fetches pc=0x0,0x4,0x8,0xC without resolve -> fetch_ready 0 after 4th; resolve in order sets indices 0,1,2,3; simultaneous fetch+resolve keeps count at 4.
- Two in flight, flush with resolve_valid=1 -> one set to oldest index, queue empty; later resolve -> no set, resolve_err=1.
- Reset asserted during sweep at index 100 -> sweep restarts from 0; with BP_STATS_EN, 3 preds/1 mispredict -> stat_pred=3, stat_mispred=1.
